// File: rtl/perf_monitor_if.sv
// Bundle between the pipeline and the performance monitor: event strobes in,
// saturating counters and run status out.
interface perf_monitor_if #(
  parameter int WIDTH = 32
);
  logic             clr;
  logic             wb_valid;
  logic             stall;
  logic             flush;
  logic             halt;
  logic [WIDTH-1:0] inst_count;
  logic [WIDTH-1:0] cycle_count;
  logic [WIDTH-1:0] stall_count;
  logic [WIDTH-1:0] flush_count;
  logic             stop;
  logic             done;

  modport master (
    output clr, wb_valid, stall, flush, halt,
    input  inst_count, cycle_count, stall_count, flush_count, stop, done
  );

  modport slave (
    input  clr, wb_valid, stall, flush, halt,
    output inst_count, cycle_count, stall_count, flush_count, stop, done
  );
endinterface

// File: rtl/perf_monitor.sv
// Pipeline performance monitor: saturating event counters that freeze a fixed
// number of drain cycles after the first halt is seen.
//
// state | meaning
// RUN   | counting, waiting for halt
// DRAIN | counting while the pipeline empties; r_drain counts down to 0
// DONE  | counters frozen; only rst or clr leave
module perf_monitor #(
  parameter int WIDTH        = 32,
  parameter int DRAIN_CYCLES = 10
) (
  input  logic           clk,
  input  logic           rst,
  perf_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LP_DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
  localparam logic [WIDTH-1:0] LP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_drain, w_drain_nxt;
  logic             r_stop, w_stop_nxt;
  logic             r_done, w_done_nxt;
  logic             w_count_en;
  logic [WIDTH-1:0] r_inst, r_cycle, r_stall, r_flush;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v,
                                               input logic en);
    if (en && !(&v)) return v + LP_ONE;
    return v;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    w_stop_nxt  = r_stop;
    w_done_nxt  = r_done;
    w_count_en  = 1'b0;
    case (r_state)
      RUN: begin
        w_count_en = 1'b1;
        if (bus.halt) begin
          w_state_nxt = DRAIN;
          w_stop_nxt  = 1'b1;
          w_drain_nxt = LP_DRAIN_LOAD;
        end
      end
      DRAIN: begin
        w_count_en = 1'b1;
        if (r_drain == 8'd0) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_drain_nxt = r_drain - 8'd1;
        end
      end
      DONE: begin
        w_count_en = 1'b0;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_drain <= '0;
      r_stop  <= 1'b0;
      r_done  <= 1'b0;
      r_inst  <= '0;
      r_cycle <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else if (bus.clr) begin
      // Soft clear overrides a simultaneous halt and the clearing cycle is not counted.
      r_state <= RUN;
      r_drain <= '0;
      r_stop  <= 1'b0;
      r_done  <= 1'b0;
      r_inst  <= '0;
      r_cycle <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
      r_stop  <= w_stop_nxt;
      r_done  <= w_done_nxt;
      r_inst  <= sat_inc(r_inst,  w_count_en && bus.wb_valid);
      r_cycle <= sat_inc(r_cycle, w_count_en);
      r_stall <= sat_inc(r_stall, w_count_en && bus.stall);
      r_flush <= sat_inc(r_flush, w_count_en && bus.flush);
    end
  end

  assign bus.inst_count  = r_inst;
  assign bus.cycle_count = r_cycle;
  assign bus.stall_count = r_stall;
  assign bus.flush_count = r_flush;
  assign bus.stop        = r_stop;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: a 32-bit and a 4-bit instance share stimulus and are
// compared against an event-count model saturated per instance width.
module tb_perf_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  perf_monitor_if #(.WIDTH(32)) if32 ();
  perf_monitor_if #(.WIDTH(4))  if4  ();

  perf_monitor #(.WIDTH(32), .DRAIN_CYCLES(10)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  perf_monitor #(.WIDTH(4),  .DRAIN_CYCLES(10)) u_dut4  (.clk(clk), .rst(rst), .bus(if4.slave));

  int n_checks = 0;
  int n_err    = 0;

  bit in_c, in_w, in_s, in_f, in_h;

  // Reference model: true event totals; a counter's expected value is the total clipped to its width.
  longint m_inst, m_cyc, m_stall, m_flush;
  bit     m_stop, m_done;
  int     m_left;

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_inst = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
    m_stop = 0; m_done = 0; m_left = 0;
  endtask

  task automatic model_step();
    if (in_c) begin
      model_reset();
    end else if (!m_done) begin
      m_cyc++;
      if (in_w) m_inst++;
      if (in_s) m_stall++;
      if (in_f) m_flush++;
      if (!m_stop) begin
        if (in_h) begin
          m_stop = 1;
          m_left = 10;
        end
      end else begin
        m_left--;
        if (m_left == 0) m_done = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("inst32",  64'(if32.inst_count),  64'(sat(m_inst, 32)));
    chk("cycle32", 64'(if32.cycle_count), 64'(sat(m_cyc, 32)));
    chk("stall32", 64'(if32.stall_count), 64'(sat(m_stall, 32)));
    chk("flush32", 64'(if32.flush_count), 64'(sat(m_flush, 32)));
    chk("stop32",  64'(if32.stop),        64'(m_stop));
    chk("done32",  64'(if32.done),        64'(m_done));
    chk("inst4",   64'(if4.inst_count),   64'(sat(m_inst, 4)));
    chk("cycle4",  64'(if4.cycle_count),  64'(sat(m_cyc, 4)));
    chk("stall4",  64'(if4.stall_count),  64'(sat(m_stall, 4)));
    chk("flush4",  64'(if4.flush_count),  64'(sat(m_flush, 4)));
    chk("stop4",   64'(if4.stop),         64'(m_stop));
    chk("done4",   64'(if4.done),         64'(m_done));
  endtask

  task automatic set_in(input bit c, input bit w, input bit s, input bit f, input bit h);
    in_c = c; in_w = w; in_s = s; in_f = f; in_h = h;
    if32.clr = c; if32.wb_valid = w; if32.stall = s; if32.flush = f; if32.halt = h;
    if4.clr  = c; if4.wb_valid  = w; if4.stall  = s; if4.flush  = f; if4.halt  = h;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap_inst, snap_cyc, snap_stall, snap_flush;
    int drain_len;

    set_in(0, 0, 0, 0, 0);
    model_reset();
    #1 rst = 1'b0;
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // 20 retiring cycles, a one-cycle halt, then the drain
    set_in(0, 1, 0, 0, 0);
    repeat (20) tick();
    chk("sat4_inst_at_20", 64'(if4.inst_count), 64'd15);
    chk("sat4_cycle_at_20", 64'(if4.cycle_count), 64'd15);
    set_in(0, 1, 0, 0, 1);
    tick();
    chk("stop_after_halt", 64'(if32.stop), 64'd1);
    set_in(0, 1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 9) chk("done_not_before_10", 64'(if32.done), 64'd0);
    end
    chk("done_after_10", 64'(if32.done), 64'd1);
    chk("cycle_total_31", 64'(if32.cycle_count), 64'd31);
    chk("inst_total_31", 64'(if32.inst_count), 64'd31);
    repeat (5) tick();
    chk("cycle_frozen_31", 64'(if32.cycle_count), 64'd31);

    set_in(1, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 1, 1, 0);
    repeat (8) tick();
    chk("stall_8", 64'(if32.stall_count), 64'd8);
    chk("flush_8", 64'(if32.flush_count), 64'd8);
    chk("inst_0", 64'(if32.inst_count), 64'd0);

    for (int i = 0; i < 30; i++) begin
      set_in(0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
      tick();
    end

    // clr and halt together: clear wins, monitor stays in RUN
    set_in(1, 1, 1, 1, 1);
    tick();
    chk("clr_halt_stop", 64'(if32.stop), 64'd0);
    chk("clr_halt_cycle", 64'(if32.cycle_count), 64'd0);
    chk("clr_halt_inst", 64'(if32.inst_count), 64'd0);
    set_in(0, 0, 0, 0, 0);
    tick();
    chk("run_after_clr", 64'(if32.cycle_count), 64'd1);

    // asynchronous reset between edges while draining
    set_in(0, 1, 0, 1, 0);
    repeat (3) tick();
    set_in(0, 1, 0, 1, 1);
    tick();
    set_in(0, 0, 1, 0, 0);
    repeat (4) tick();
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_cycle", 64'(if32.cycle_count), 64'd0);
    #1 rst = 1'b1;
    set_in(0, 1, 0, 0, 0);
    repeat (5) tick();
    // halt held high through the drain must not restart it
    set_in(0, 1, 1, 0, 1);
    tick();
    drain_len = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (if32.done === 1'b1 && drain_len == 0) drain_len = i;
    end
    chk("drain_len_after_rst", 64'(drain_len), 64'd10);

    snap_inst  = if32.inst_count;
    snap_cyc   = if32.cycle_count;
    snap_stall = if32.stall_count;
    snap_flush = if32.flush_count;
    for (int i = 0; i < 50; i++) begin
      set_in(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      chk("done_hold_inst", 64'(if32.inst_count), 64'(snap_inst));
      chk("done_hold_cycle", 64'(if32.cycle_count), 64'(snap_cyc));
      chk("done_hold_stall", 64'(if32.stall_count), 64'(snap_stall));
      chk("done_hold_flush", 64'(if32.flush_count), 64'(snap_flush));
      chk("done_hold_flags", 64'({if32.stop, if32.done}), 64'd3);
    end

    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 24) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
